// File: rtl/vga_sync_gen_if.sv
// Video timing bundle between the VGA sync generator and the pixel/RGB generator.
// The sync generator drives everything; the pixel generator only observes.
interface vga_sync_gen_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;

    modport master (
        output hsync,
        output vsync,
        output video_on,
        output p_tick,
        output pixel_x,
        output pixel_y,
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input video_on,
        input p_tick,
        input pixel_x,
        input pixel_y,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator: pixel-rate divider, h/v counters and
// registered sync/blanking outputs that always match the counters shown alongside them.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vid
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);
    localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);

    // Sync windows use 11 bits so an end boundary of exactly 1024 still compares correctly.
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;

    logic          p_tick;
    logic          x_last;
    logic          y_last;
    logic [10:0]   x_ext;
    logic [10:0]   y_ext;

    always_comb begin
        p_tick = (div_q == DIV_MAX);
        x_last = (x_q == H_MAX);
        y_last = (y_q == V_MAX);
    end

    // Next-state: counters step only on the pixel tick; sync/blank flags are decoded
    // from the next counter values so they land on the same edge as the counters.
    always_comb begin
        div_d      = div_q;
        x_d        = x_q;
        y_d        = y_q;
        x_ext      = 11'd0;
        y_ext      = 11'd0;
        hsync_d    = 1'b1;
        vsync_d    = 1'b1;
        video_on_d = 1'b1;

        div_d = p_tick ? '0 : (div_q + DIV_ONE);

        if (p_tick) begin
            x_d = x_last ? 10'd0 : (x_q + 10'd1);
            if (x_last) begin
                y_d = y_last ? 10'd0 : (y_q + 10'd1);
            end
        end

        x_ext      = {1'b0, x_d};
        y_ext      = {1'b0, y_d};
        hsync_d    = !((x_ext >= HS_START) && (x_ext < HS_END));
        vsync_d    = !((y_ext >= VS_START) && (y_ext < VS_END));
        video_on_d = (x_ext < H_VIS) && (y_ext < V_VIS);
    end

    // Reset parks the raster at (0,0) with both syncs deasserted, cutting any pulse short.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.video_on    = video_on_q;
    assign vid.p_tick      = p_tick;
    assign vid.pixel_x     = x_q;
    assign vid.pixel_y     = y_q;
    assign vid.frame_start = p_tick && x_last && y_last;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a tiny-raster instance,
// both compared every clock against an arithmetic model driven by elapsed clock count.
module tb_vga_sync_gen;
    logic clk;
    logic reset;

    vga_sync_gen_if ifA ();
    vga_sync_gen_if ifB ();

    vga_sync_gen dutA (
        .clk   (clk),
        .reset (reset),
        .vid   (ifA)
    );

    // Small raster: 15 pixels x 8 lines, 3 clk per pixel -> 360 clk per frame.
    vga_sync_gen #(
        .CLK_DIV   (3),
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_DISPLAY (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dutB (
        .clk   (clk),
        .reset (reset),
        .vid   (ifB)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       fs;
    } exp_t;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n = clock edges seen with reset low since the last reset edge.
    function automatic exp_t model(input int cnt, input int cdiv,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb);
        exp_t r;
        int ht, vt, p, xi, yi;
        ht    = hd + hf + hsw + hb;
        vt    = vd + vf + vsw + vb;
        p     = cnt / cdiv;
        xi    = p % ht;
        yi    = (p / ht) % vt;
        r.x   = 10'(xi);
        r.y   = 10'(yi);
        r.pt  = ((cnt % cdiv) == cdiv - 1);
        r.hs  = !((xi >= hd + hf) && (xi < hd + hf + hsw));
        r.vs  = !((yi >= vd + vf) && (yi < vd + vf + vsw));
        r.von = (xi < hd) && (yi < vd);
        r.fs  = r.pt && (xi == ht - 1) && (yi == vt - 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic checkOutput();
        exp_t a, b;
        a = model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
        b = model(n, 3, 8, 2, 3, 2, 4, 1, 2, 1);
        chk("A.pixel_x", ifA.pixel_x, a.x);
        chk("A.pixel_y", ifA.pixel_y, a.y);
        chk("A.hsync", ifA.hsync, a.hs);
        chk("A.vsync", ifA.vsync, a.vs);
        chk("A.video_on", ifA.video_on, a.von);
        chk("A.p_tick", ifA.p_tick, a.pt);
        chk("A.frame_start", ifA.frame_start, a.fs);
        chk("B.pixel_x", ifB.pixel_x, b.x);
        chk("B.pixel_y", ifB.pixel_y, b.y);
        chk("B.hsync", ifB.hsync, b.hs);
        chk("B.vsync", ifB.vsync, b.vs);
        chk("B.video_on", ifB.video_on, b.von);
        chk("B.p_tick", ifB.p_tick, b.pt);
        chk("B.frame_start", ifB.frame_start, b.fs);
    endtask

    // Inputs change only on the falling edge; outputs are checked there too.
    task automatic applyStimulus();
        @(posedge clk);
        if (reset) n = 0;
        else       n++;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        int hLow, fsCount, vonCount, vFalls, firstFall, secondFall;
        logic prevVs;

        reset = 1'b1;
        repeat (3) applyStimulus();
        reset = 1'b0;

        // One full default line: hsync low width and the 799->0 / y 0->1 wrap.
        hLow = 0;
        repeat (1600) begin
            applyStimulus();
            if (ifA.hsync === 1'b0) hLow++;
        end
        chk("A.hsync_low_width", hLow, 192);
        chk("A.wrap_x", ifA.pixel_x, 0);
        chk("A.wrap_y", ifA.pixel_y, 1);
        repeat (1700) applyStimulus();

        // Three small frames from reset: frame pulses, visible time, vsync period.
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        fsCount = 0; vonCount = 0; vFalls = 0; firstFall = 0; secondFall = 0;
        prevVs = ifB.vsync;
        repeat (1080) begin
            applyStimulus();
            if (ifB.frame_start === 1'b1) fsCount++;
            if (ifB.video_on === 1'b1) vonCount++;
            if (prevVs === 1'b1 && ifB.vsync === 1'b0) begin
                vFalls++;
                if (vFalls == 1) firstFall = n;
                if (vFalls == 2) secondFall = n;
            end
            prevVs = ifB.vsync;
        end
        chk("B.frame_start_count", fsCount, 3);
        chk("B.video_on_clks", vonCount, 288);
        chk("B.vsync_falls", vFalls, 3);
        chk("B.vsync_period", secondFall - firstFall, 360);

        // Reset while B sits inside both sync pulses at (11,5).
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        repeat (258) applyStimulus();
        chk("B.pre_reset_x", ifB.pixel_x, 11);
        chk("B.pre_reset_hsync", ifB.hsync, 0);
        chk("B.pre_reset_vsync", ifB.vsync, 0);
        reset = 1'b1;
        applyStimulus();
        chk("B.reset_x", ifB.pixel_x, 0);
        chk("B.reset_y", ifB.pixel_y, 0);
        chk("B.reset_hsync", ifB.hsync, 1);
        chk("B.reset_vsync", ifB.vsync, 1);
        chk("B.reset_p_tick", ifB.p_tick, 0);
        applyStimulus();
        reset = 1'b0;
        repeat (50) applyStimulus();

        // Random run lengths interleaved with random-length resets.
        for (int k = 0; k < 15; k++) begin
            repeat ($urandom_range(800, 1)) applyStimulus();
            reset = 1'b1;
            repeat ($urandom_range(3, 1)) applyStimulus();
            reset = 1'b0;
        end
        repeat (400) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
